// File: rtl/control_pipe_if.sv
// control_pipe_if: ID-stage inputs and staged control outputs of the pipelined control unit.
interface control_pipe_if #(
    parameter int OPW  = 6,
    parameter int REGW = 5
);
    logic [OPW-1:0]  opcode;
    logic [REGW-1:0] id_rs;
    logic [REGW-1:0] id_rt;
    logic            ex_zero;

    logic            ex_RegDst;
    logic            ex_ALUSrc;
    logic [1:0]      ex_ALUOp;
    logic            ex_Branch;
    logic            ex_Jump;
    logic            mem_MemRead;
    logic            mem_MemWrite;
    logic            wb_MemtoReg;
    logic            wb_RegWrite;
    logic            stall;
    logic            flush_ifid;
    logic            hilo_we;
    logic            madd_busy;
    logic            bad_opcode;

    modport master (
        output opcode, id_rs, id_rt, ex_zero,
        input  ex_RegDst, ex_ALUSrc, ex_ALUOp, ex_Branch, ex_Jump,
        input  mem_MemRead, mem_MemWrite, wb_MemtoReg, wb_RegWrite,
        input  stall, flush_ifid, hilo_we, madd_busy, bad_opcode
    );

    modport slave (
        input  opcode, id_rs, id_rt, ex_zero,
        output ex_RegDst, ex_ALUSrc, ex_ALUOp, ex_Branch, ex_Jump,
        output mem_MemRead, mem_MemWrite, wb_MemtoReg, wb_RegWrite,
        output stall, flush_ifid, hilo_we, madd_busy, bad_opcode
    );
endinterface

// File: rtl/control_pipe.sv
// control_pipe: pipelined MIPS-Lite control with load-use stall, branch/jump flush and MADDU sequencing.
// Define CTRL_MADDU_EN to build MADDU decode and its multi-cycle EX occupancy FSM.
module control_pipe #(
    parameter int OPW          = 6,
    parameter int REGW         = 5,
    parameter int MADDU_CYCLES = 4
) (
    input logic           clk,
    input logic           rst,
    control_pipe_if.slave bus
);

    localparam logic [OPW-1:0] OP_R     = OPW'(0);
    localparam logic [OPW-1:0] OP_LW    = OPW'(35);
    localparam logic [OPW-1:0] OP_SW    = OPW'(43);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(4);
    localparam logic [OPW-1:0] OP_J     = OPW'(2);
    localparam logic [OPW-1:0] OP_ADDIU = OPW'(9);
`ifdef CTRL_MADDU_EN
    localparam logic [OPW-1:0] OP_MADDU = OPW'(28);
`endif

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic [1:0] alu_op;
    } ctrl_t;

    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
        logic mem_read;
        logic mem_write;
    } mem_ctrl_t;

    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
    } wb_ctrl_t;

    ctrl_t           id_ctrl;
    logic            id_illegal;
    ctrl_t           ex_ctrl_q, ex_ctrl_d;
    logic [REGW-1:0] ex_rt_q, ex_rt_d;
    mem_ctrl_t       mem_ctrl_q, mem_ctrl_d;
    wb_ctrl_t        wb_ctrl_q, wb_ctrl_d;
    logic            bad_q, bad_d;

    logic take;
    logic load_use;
    logic stall_raw;
    logic madd_stall;
    logic madd_done;
    logic madd_busy;

    always_comb begin
        id_ctrl    = '0;
        id_illegal = 1'b0;
        case (bus.opcode)
            OP_R: begin
                id_ctrl.reg_dst   = 1'b1;
                id_ctrl.reg_write = 1'b1;
                id_ctrl.alu_op    = 2'b10;
            end
            OP_LW: begin
                id_ctrl.alu_src    = 1'b1;
                id_ctrl.mem_to_reg = 1'b1;
                id_ctrl.reg_write  = 1'b1;
                id_ctrl.mem_read   = 1'b1;
            end
            OP_SW: begin
                id_ctrl.alu_src   = 1'b1;
                id_ctrl.mem_write = 1'b1;
            end
            OP_BEQ: begin
                id_ctrl.branch = 1'b1;
                id_ctrl.alu_op = 2'b01;
            end
            OP_J:     id_ctrl.jump = 1'b1;
            OP_ADDIU: begin
                id_ctrl.alu_src   = 1'b1;
                id_ctrl.reg_write = 1'b1;
            end
`ifdef CTRL_MADDU_EN
            OP_MADDU: id_ctrl.alu_op = 2'b11;
`endif
            default:  id_illegal = 1'b1;
        endcase
    end

    assign take      = (ex_ctrl_q.branch & bus.ex_zero) | ex_ctrl_q.jump;
    assign load_use  = ex_ctrl_q.mem_read & ((ex_rt_q == bus.id_rs) | (ex_rt_q == bus.id_rt));
    assign stall_raw = madd_stall | (~take & load_use);

`ifdef CTRL_MADDU_EN
    typedef enum logic {IDLE, BUSY} madd_state_e;

    localparam int CNTW = $clog2(MADDU_CYCLES) + 1;
    localparam logic [CNTW-1:0] CNT_INIT = (MADDU_CYCLES > 1) ? CNTW'(MADDU_CYCLES - 2) : '0;

    madd_state_e     state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            madd_in_ex;

    assign madd_in_ex = (ex_ctrl_q.alu_op == 2'b11);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (madd_in_ex && (MADDU_CYCLES > 1)) begin
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // The BUSY cycle with cnt==0 is MADDU's last EX cycle: no stall, result commits.
    always_comb begin
        madd_stall = 1'b0;
        madd_done  = 1'b0;
        madd_busy  = 1'b0;
        case (state_q)
            IDLE: begin
                madd_stall = madd_in_ex && (MADDU_CYCLES > 1);
                madd_done  = madd_in_ex && (MADDU_CYCLES == 1);
            end
            BUSY: begin
                madd_busy  = 1'b1;
                madd_stall = (cnt_q != '0);
                madd_done  = (cnt_q == '0);
            end
            default: ;
        endcase
    end
`else
    logic unused_cfg;
    assign unused_cfg = (MADDU_CYCLES > 1);
    assign madd_stall = 1'b0;
    assign madd_done  = 1'b0;
    assign madd_busy  = 1'b0;
`endif

    // MADDU holds ID/EX and bubbles EX/MEM; flush and load-use both insert an ID/EX bubble.
    always_comb begin
        ex_ctrl_d = ex_ctrl_q;
        ex_rt_d   = ex_rt_q;
        if (!madd_stall) begin
            ex_rt_d   = bus.id_rt;
            ex_ctrl_d = (take || load_use) ? '0 : id_ctrl;
        end
        mem_ctrl_d = madd_stall ? '0 : '{ex_ctrl_q.mem_to_reg, ex_ctrl_q.reg_write,
                                         ex_ctrl_q.mem_read, ex_ctrl_q.mem_write};
        wb_ctrl_d  = '{mem_ctrl_q.mem_to_reg, mem_ctrl_q.reg_write};
        bad_d      = id_illegal & ~stall_raw & ~take;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_ctrl_q  <= '0;
            ex_rt_q    <= '0;
            mem_ctrl_q <= '0;
            wb_ctrl_q  <= '0;
            bad_q      <= 1'b0;
        end else begin
            ex_ctrl_q  <= ex_ctrl_d;
            ex_rt_q    <= ex_rt_d;
            mem_ctrl_q <= mem_ctrl_d;
            wb_ctrl_q  <= wb_ctrl_d;
            bad_q      <= bad_d;
        end
    end

    assign bus.ex_RegDst    = ex_ctrl_q.reg_dst;
    assign bus.ex_ALUSrc    = ex_ctrl_q.alu_src;
    assign bus.ex_ALUOp     = ex_ctrl_q.alu_op;
    assign bus.ex_Branch    = ex_ctrl_q.branch;
    assign bus.ex_Jump      = ex_ctrl_q.jump;
    assign bus.mem_MemRead  = mem_ctrl_q.mem_read;
    assign bus.mem_MemWrite = mem_ctrl_q.mem_write;
    assign bus.wb_MemtoReg  = wb_ctrl_q.mem_to_reg;
    assign bus.wb_RegWrite  = wb_ctrl_q.reg_write;
    assign bus.stall        = stall_raw & ~rst;
    assign bus.flush_ifid   = take & ~rst;
    assign bus.hilo_we      = madd_done & ~rst;
    assign bus.madd_busy    = madd_busy;
    assign bus.bad_opcode   = bad_q;

endmodule

// File: tb/tb_control_pipe.sv
// tb_control_pipe: directed vector table, MADDU/reset sequences and a randomized run
// against a stage-occupancy model of the control pipeline.
module tb_control_pipe;

    localparam int MC = 4;
`ifdef CTRL_MADDU_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    control_pipe_if #(.OPW(6), .REGW(5)) bus ();

    control_pipe #(.OPW(6), .REGW(5), .MADDU_CYCLES(MC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passes = 0;

    typedef struct {
        int rst;
        int op;
        int rs;
        int rt;
        int zero;
        int ex;
        int mem;
        int wb;
        int st;
        int fl;
        int bad;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    // Reference model state: opcode occupying each stage (-1 = bubble)
    int m_ex, m_mem, m_wb, m_ex_rt, m_age, m_bad;

    task automatic applyStimulus(input int r, input int op, input int rs, input int rt, input int z);
        rst         = (r != 0);
        bus.opcode  = 6'(op);
        bus.id_rs   = 5'(rs);
        bus.id_rt   = 5'(rt);
        bus.ex_zero = (z != 0);
        @(negedge clk);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    function automatic logic [5:0] exVec();
        return {bus.ex_RegDst, bus.ex_ALUSrc, bus.ex_ALUOp, bus.ex_Branch, bus.ex_Jump};
    endfunction

    function automatic logic [14:0] allOut();
        return {exVec(), bus.mem_MemRead, bus.mem_MemWrite, bus.wb_MemtoReg, bus.wb_RegWrite,
                bus.stall, bus.flush_ifid, bus.hilo_we, bus.madd_busy, bus.bad_opcode};
    endfunction

    // {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Jump,ALUOp}
    function automatic logic [9:0] dec(input int op);
        case (op)
            0:       return 10'b1001000010;
            35:      return 10'b0111100000;
            43:      return 10'b0100010000;
            4:       return 10'b0000001001;
            2:       return 10'b0000000100;
            9:       return 10'b0101000000;
            28:      return EN ? 10'b0000000011 : 10'b0;
            default: return 10'b0;
        endcase
    endfunction

    function automatic bit implemented(input int op);
        return (op == 0) || (op == 35) || (op == 43) || (op == 4) || (op == 2) || (op == 9) || (EN && op == 28);
    endfunction

    function automatic int pickOp();
        case ($urandom_range(0, 9))
            0, 9:    return 0;
            1, 2:    return 35;
            3:       return 43;
            4:       return 4;
            5:       return 2;
            6:       return 9;
            7:       return 28;
            default: return int'($urandom_range(0, 63));
        endcase
    endfunction

    initial begin
        logic [9:0]  dx, dm, dw;
        logic [14:0] expv;
        bit          madd, mstall, take, lu, estall;
        int          op, rs, rt, r, z;
        bit          hold;

        vecs[0]  = '{1,  0, 0, 0, 0, 'b000000, 'b00, 'b00, 0, 0, 0};
        vecs[1]  = '{0, 35, 1, 8, 0, 'b000000, 'b00, 'b00, 0, 0, 0};
        vecs[2]  = '{0,  0, 8, 2, 0, 'b010000, 'b00, 'b00, 1, 0, 0};
        vecs[3]  = '{0,  0, 8, 2, 0, 'b000000, 'b10, 'b00, 0, 0, 0};
        vecs[4]  = '{0,  9, 3, 4, 0, 'b101000, 'b00, 'b11, 0, 0, 0};
        vecs[5]  = '{0,  4, 1, 1, 0, 'b010000, 'b00, 'b00, 0, 0, 0};
        vecs[6]  = '{0,  0, 5, 6, 1, 'b000110, 'b00, 'b01, 0, 1, 0};
        vecs[7]  = '{0,  4, 0, 0, 1, 'b000000, 'b00, 'b01, 0, 0, 0};
        vecs[8]  = '{0,  2, 0, 0, 0, 'b000110, 'b00, 'b00, 0, 0, 0};
        vecs[9]  = '{0, 35, 1, 7, 0, 'b000001, 'b00, 'b00, 0, 1, 0};
        vecs[10] = '{0, 35, 2, 9, 0, 'b000000, 'b00, 'b00, 0, 0, 0};
        vecs[11] = '{0,  2, 0, 0, 0, 'b010000, 'b00, 'b00, 0, 0, 0};
        vecs[12] = '{0,  0, 0, 0, 0, 'b000001, 'b10, 'b00, 0, 1, 0};
        vecs[13] = '{0, 63, 1, 1, 0, 'b000000, 'b00, 'b11, 0, 0, 0};
        vecs[14] = '{0,  9, 1, 2, 0, 'b000000, 'b00, 'b00, 0, 0, 1};
        vecs[15] = '{0,  0, 0, 0, 0, 'b010000, 'b00, 'b00, 0, 0, 0};

        rst         = 1'b1;
        bus.opcode  = '0;
        bus.id_rs   = '0;
        bus.id_rt   = '0;
        bus.ex_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].zero);
            checkOutput($sformatf("vec%0d_ex", i),    32'(exVec()), vecs[i].ex);
            checkOutput($sformatf("vec%0d_mem", i),   32'({bus.mem_MemRead, bus.mem_MemWrite}), vecs[i].mem);
            checkOutput($sformatf("vec%0d_wb", i),    32'({bus.wb_MemtoReg, bus.wb_RegWrite}), vecs[i].wb);
            checkOutput($sformatf("vec%0d_stall", i), 32'(bus.stall), vecs[i].st);
            checkOutput($sformatf("vec%0d_flush", i), 32'(bus.flush_ifid), vecs[i].fl);
            checkOutput($sformatf("vec%0d_bad", i),   32'(bus.bad_opcode), vecs[i].bad);
            nextCycle();
        end

        // MADDU occupancy: k counts the EX cycles of the MADDU
        applyStimulus(1, 0, 0, 0, 0);
        nextCycle();
        applyStimulus(0, 28, 0, 0, 0);
        nextCycle();
        for (int k = 1; k <= MC; k++) begin
            applyStimulus(0, 0, 1, 2, 0);
            checkOutput($sformatf("madd_stall_k%0d", k), 32'(bus.stall),     32'(EN && k < MC));
            checkOutput($sformatf("madd_busy_k%0d", k),  32'(bus.madd_busy), 32'(EN && k >= 2));
            checkOutput($sformatf("madd_hilo_k%0d", k),  32'(bus.hilo_we),   32'(EN && k == MC));
            checkOutput($sformatf("madd_mem_k%0d", k),   32'({bus.mem_MemRead, bus.mem_MemWrite}), 0);
            if (k == 1) begin
                checkOutput("madd_aluop", 32'(bus.ex_ALUOp),    EN ? 32'd3 : 32'd0);
                checkOutput("op28_bad",   32'(bus.bad_opcode),  32'(!EN));
            end
            nextCycle();
        end
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("madd_after_aluop", 32'(bus.ex_ALUOp),  32'd2);
        checkOutput("madd_after_busy",  32'(bus.madd_busy), 0);
        checkOutput("madd_after_hilo",  32'(bus.hilo_we),   0);
        nextCycle();

        // Reset while the MADDU is mid-BUSY
        applyStimulus(0, 28, 0, 0, 0);
        nextCycle();
        applyStimulus(0, 0, 1, 2, 0);
        nextCycle();
        applyStimulus(0, 0, 1, 2, 0);
        checkOutput("rstb_busy", 32'(bus.madd_busy), 32'(EN));
        nextCycle();
        applyStimulus(1, 0, 1, 2, 0);
        nextCycle();
        applyStimulus(0, 0, 1, 2, 0);
        checkOutput("rstb_all_zero", 32'(allOut()), 0);
        nextCycle();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 1, 2, 0);
            checkOutput($sformatf("rstb_hilo_%0d", k), 32'(bus.hilo_we),   0);
            checkOutput($sformatf("rstb_busy_%0d", k), 32'(bus.madd_busy), 0);
            nextCycle();
        end

        // Randomized run against the stage-occupancy model
        applyStimulus(1, 0, 0, 0, 0);
        nextCycle();
        m_ex = -1; m_mem = -1; m_wb = -1; m_ex_rt = 0; m_age = 0; m_bad = 0;
        hold = 1'b0;
        op = 0; rs = 0; rt = 0;
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 63) == 0) ? 1 : 0;
            if (!hold) begin
                op = pickOp();
                rs = int'($urandom_range(0, 3));
                rt = int'($urandom_range(0, 3));
            end
            z = int'($urandom_range(0, 1));
            applyStimulus(r, op, rs, rt, z);

            dx     = dec(m_ex);
            dm     = dec(m_mem);
            dw     = dec(m_wb);
            madd   = EN && (m_ex == 28);
            mstall = madd && (m_age < MC);
            take   = (dx[3] && z != 0) || dx[2];
            lu     = dx[5] && (m_ex_rt == rs || m_ex_rt == rt);
            estall = mstall || (!take && lu);
            expv   = {dx[9], dx[8], dx[1:0], dx[3], dx[2], dm[5], dm[4], dw[7], dw[6],
                      (r == 0) && estall, (r == 0) && take, (r == 0) && madd && (m_age == MC),
                      madd && (m_age >= 2), m_bad != 0};
            checkOutput($sformatf("rand_cycle%0d", n), 32'(allOut()), 32'(expv));

            if (r != 0) begin
                m_ex = -1; m_mem = -1; m_wb = -1; m_ex_rt = 0; m_age = 0; m_bad = 0;
                hold = 1'b0;
            end else begin
                m_bad = (!implemented(op) && !estall && !take) ? 1 : 0;
                m_wb  = m_mem;
                m_mem = mstall ? -1 : m_ex;
                if (mstall) begin
                    m_age = m_age + 1;
                end else begin
                    m_age   = 1;
                    m_ex_rt = rt;
                    m_ex    = (take || lu) ? -1 : op;
                end
                hold = estall;
            end
            nextCycle();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/control_pipe.md
Name: control_pipe

Overview:
- Pipelined successor to the single-cycle MIPS-Lite control unit.
- Decodes opcode in ID and carries control bits through ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards, flushes on taken branch/jump, and sequences multi-cycle MADDU with a counter FSM.
- Sits between the IF/ID register and the datapath stage muxes; drives PC/IF-ID stall and flush.

Parameters:
- OPW, 6, opcode width.
- REGW, 5, register-specifier width.
- MADDU_CYCLES, 4, EX occupancy of MADDU in cycles (>=1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- opcode  in  OPW  ID-stage opcode.
- id_rs  in  REGW  ID-stage rs field.
- id_rt  in  REGW  ID-stage rt field.
- ex_zero  in  1  ALU zero flag of the instruction in EX.
- ex_RegDst, ex_ALUSrc  out  1  EX mux selects.
- ex_ALUOp  out  2  to ALU control.
- ex_Branch, ex_Jump  out  1  EX-stage branch/jump flags.
- mem_MemRead, mem_MemWrite  out  1  data-memory controls.
- wb_MemtoReg, wb_RegWrite  out  1  writeback controls.
- stall  out  1  hold PC and IF/ID.
- flush_ifid  out  1  squash IF/ID.
- hilo_we  out  1  one-cycle pulse: MADDU result commit.
- madd_busy  out  1  MADDU FSM not IDLE.
- bad_opcode  out  1  registered one-cycle pulse: unimplemented opcode decoded.

Behaviour:
- Decode (combinational, ID), in the order RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp:
  - R(0) = 1,0,0,1,0,0,0,0,10
  - LW(35) = 0,1,1,1,1,0,0,0,00
  - SW(43) = 0,1,0,0,0,1,0,0,00
  - BEQ(4) = 0,0,0,0,0,0,1,0,01
  - J(2) = 0,0,0,0,0,0,0,1,00
  - ADDIU(9) = 0,1,0,1,0,0,0,0,00
  - MADDU(28) = 0,0,0,0,0,0,0,0,11
- No X values on any output. Any other opcode decodes as a bubble (all 0) and pulses bad_opcode the next cycle.
- Bubble = all control bits 0; ID/EX also stores id_rt as ex_rt.
- Reset: all three stage registers become bubbles, FSM to IDLE, every output 0.
- Latency: decode appears on ex_* 1 cycle after being in ID, on mem_* after 2, on wb_* after 3.
- Load-use: load_use = ex_MemRead & (ex_rt==id_rs | ex_rt==id_rt).
  - When set: stall=1, IF/ID held, ID/EX loads a bubble. Exactly 1 stall cycle.
- Flush: take = (ex_Branch & ex_zero) | ex_Jump.
  - When set: flush_ifid=1, ID/EX loads a bubble next edge, and load_use is ignored (flush has priority).
  - EX/MEM advances normally.
- MADDU FSM, states IDLE and BUSY, counter cnt of width clog2(MADDU_CYCLES)+1:
  - IDLE: when ex_ALUOp==11 and MADDU_CYCLES>1, go to BUSY with cnt=MADDU_CYCLES-2. stall=1 in this same cycle.
  - BUSY: stall=1; ID/EX holds MADDU; EX/MEM loads bubbles; cnt decrements. When cnt==0, return to IDLE.
  - The cycle MADDU finally leaves EX: hilo_we=1 for 1 cycle, and EX/MEM receives MADDU's (inert) control bits.
  - MADDU_CYCLES==1: no stall, hilo_we pulses in its single EX cycle.
- Priority: MADDU stall > flush > load-use.
  - MADDU in EX excludes branch/jump in EX, so flush cannot coincide with BUSY.
- Back-to-back MADDU: the second enters EX after the first leaves, then starts a fresh BUSY.
- rst mid-BUSY: FSM goes to IDLE the next edge and hilo_we is not asserted.
- MEM/WB always advances; writeback is never stalled.

Optional Feature:
- Macro CTRL_MADDU_EN.
- Defined: MADDU decode and FSM as above.
- Undefined: opcode 28 is treated as unimplemented (bubble + bad_opcode). FSM and counter are not built; madd_busy and hilo_we are tied to 0.

Test Plan:
- LW (rt=8) then R-type using rs=8 -> stall=1 for exactly 1 cycle. The bubble reaches EX. wb_RegWrite=1 for LW at cycle 3, then for the R-type at cycle 5.
- BEQ with ex_zero=1 -> flush_ifid=1 for 1 cycle; next ex_* all 0. With ex_zero=0 -> no flush.
- J -> flush_ifid=1 the cycle J is in EX. Coincident load-use in ID -> stall stays 0.
- MADDU with MADDU_CYCLES=4 -> stall high 3 cycles, madd_busy high 3 cycles, hilo_we pulses once in the 4th EX cycle, EX/MEM carries 3 bubbles.
- Opcode 63 -> bad_opcode pulse 1 cycle later, all ex_* 0. Assert rst during MADDU BUSY -> all outputs 0 the next cycle, no hilo_we.
- Build without CTRL_MADDU_EN: opcode 28 -> bad_opcode=1, stall=0, hilo_we=0.
